mux16_rr_arbiter: RTL and testbench
===================================

Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 1-bit, 16:1 select path among 16 requesters.
- Each cycle it chooses which requester owns the select lines, drives a one-hot grant and the 4-bit select, and registers the selected data bit with a valid flag.
- Sits in front of the 16:1 multiplexer tree.
- Enforces fairness with a circular priority pointer and a per-grant beat limit.

Parameters:
- MAX_HOLD, 4: maximum consecutive beats one grantee keeps the path while others are waiting. 0 means unlimited.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request per requester; bit i = requester i.
- a  input  16  data bit per requester.
- gnt  output  16  one-hot grant, registered. All zeros when idle.
- sel  output  4  index of current grantee, registered. Drives the 16:1 select.
- busy  output  1  high while in GRANT state.
- y  output  1  registered data bit, taken from a[sel] on a beat.
- y_vld  output  1  high for one cycle per beat, in the cycle after that beat.

Behaviour:
- Clock and reset: single clock. rst_n is asynchronous and active-low.
- Reset values (applied immediately, including mid-grant): gnt=0, sel=0, busy=0, y=0, y_vld=0, ptr=0, hold_cnt=0, state=IDLE.
- Internal state: ptr[3:0] is the search start point; hold_cnt counts beats.
- Pick function: search circularly ptr, ptr+1, …, 15, 0, …, ptr-1. Select the first set bit of the masked request vector.
- IDLE state:
  - If req is nonzero: at the next edge load gnt/sel with the winner, set busy=1, hold_cnt=0, go to GRANT.
  - Latency: req sampled at edge N gives gnt valid after edge N.
  - Otherwise stay in IDLE.
- Beat definition: a GRANT cycle with req[sel]=1. At that edge y<=a[sel], y_vld<=1, hold_cnt<=hold_cnt+1.
  - In any non-beat cycle, y_vld<=0 and y holds its value.
- Release (GRANT, req[sel]=0): not a beat.
  - ptr<=sel+1, wrapping mod 16 (15 wraps to 0).
  - Pick among the remaining requests with mask ~(1<<sel), starting at sel+1.
  - If a winner is found: regrant at the same edge, no idle bubble, hold_cnt=0.
  - If none is found: go to IDLE, gnt=0, busy=0.
- Hold limit (MAX_HOLD≠0): on a beat where hold_cnt+1==MAX_HOLD:
  - If any other req bit is set: rotate. ptr<=sel+1, grant the circular winner excluding sel, hold_cnt=0.
  - If no other requester: keep the grant, hold_cnt=0.
- Simultaneous events: release takes precedence over hold-limit rotation. The newly granted requester never gets a beat in its grant edge cycle.
- hold_cnt width is clog2(MAX_HOLD+1), minimum 1. It never exceeds MAX_HOLD-1 after an edge.
- gnt is always one-hot or zero, and gnt[sel]=1 whenever busy=1.
- Requests appearing or disappearing on non-grantees have no effect until the next arbitration edge.

Decomposition:
- Package mux_arb_pkg holds:
  - NREQ=16, SEL_W=4.
  - State enum {IDLE, GRANT}.
  - Helper function to convert index to one-hot.
- Sub-module rr_pick16 (combinational):
  - Inputs: req[15:0], mask[15:0], ptr[3:0].
  - Outputs: idx[3:0], found.
  - Instantiated once.
- The data select a[sel] is made inside the block, not through the existing mux tree, so the y==a[sel] contract is exact.

Test Plan:
- Reset then req=16'h0001, a[0]=1 → gnt=16'h0001 and sel=0 one edge later; y=1 with y_vld=1 on the following cycle; busy=1.
- req=16'h8001 held, MAX_HOLD=4, grant on 0 → exactly 4 beats on sel=0, then sel=15 for 4 beats, then back to 0; no idle cycle between grants.
- Grant on sel=15, drop req[15] while req[2]=1 → same edge gnt=16'h0004 and ptr wrap-around verified; y_vld=0 for the release cycle.
- Only req[5] held for 10 cycles, MAX_HOLD=4 → grant stays on 5 for all 10 beats, hold_cnt restarts, y_vld continuous.
- rst_n pulsed low mid-grant (asynchronous, between edges) → gnt, sel, busy, y and y_vld clear immediately; after release, req=16'hFFFF grants index 0 first.
- All 16 requesters held, MAX_HOLD=1 → sel sequence 0,1,2,…,15,0 one grant per beat; gnt always one-hot (assertion).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, FSM states and index-to-one-hot helper for the 16:1 arbiter
package mux_arb_pkg;
    localparam int NREQ = 16;
    localparam int SEL_W = 4;
    typedef enum logic {IDLE, GRANT} state_e;
    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: first set bit of req & mask, searching circularly from ptr
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [NREQ-1:0] m;
    logic [SEL_W-1:0] j;
    assign m = req & mask;
    // walk offsets from far to near so the nearest hit to ptr wins
    always_comb begin
        idx = '0;
        found = 1'b0;
        j = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = ptr + SEL_W'(k);
            if (m[j]) begin
                idx = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner of a shared 16:1 select path with a per-grant beat limit
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  a,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             y,
    output logic             y_vld
);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    state_e state_q;
    logic [NREQ-1:0] gnt_q, pick_mask;
    logic [SEL_W-1:0] sel_q, ptr_q, nxt_ptr, pick_ptr, pick_idx;
    logic [HW-1:0] hold_q, hold_d;
    logic y_q, vld_q, beat, at_limit, pick_found;
    assign nxt_ptr = sel_q + 1'b1;
    assign beat = (state_q == GRANT) && req[sel_q];
    assign hold_d = hold_q + 1'b1;
    assign at_limit = (MAX_HOLD != 0) && (hold_d == HW'(MAX_HOLD));
    // while granted, the search always excludes the grantee and starts just past it
    assign pick_ptr = (state_q == IDLE) ? ptr_q : nxt_ptr;
    assign pick_mask = (state_q == IDLE) ? '1 : ~onehot(sel_q);
    rr_pick16 u_pick (
        .req   (req),
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q <= '0;
            sel_q <= '0;
            ptr_q <= '0;
            hold_q <= '0;
            y_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= beat;
            if (beat) y_q <= a[sel_q];
            if (state_q == IDLE) begin
                if (pick_found) begin
                    state_q <= GRANT;
                    sel_q <= pick_idx;
                    gnt_q <= onehot(pick_idx);
                    hold_q <= '0;
                end
            end else if (!beat) begin
                ptr_q <= nxt_ptr;
                hold_q <= '0;
                if (pick_found) begin
                    sel_q <= pick_idx;
                    gnt_q <= onehot(pick_idx);
                end else begin
                    state_q <= IDLE;
                    gnt_q <= '0;
                end
            end else if (at_limit) begin
                hold_q <= '0;
                if (pick_found) begin
                    ptr_q <= nxt_ptr;
                    sel_q <= pick_idx;
                    gnt_q <= onehot(pick_idx);
                end
            end else begin
                hold_q <= hold_d;
            end
        end
    end
    assign gnt = gnt_q;
    assign sel = sel_q;
    assign busy = (state_q == GRANT);
    assign y = y_q;
    assign y_vld = vld_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: random and directed checks of two arbiter instances (MAX_HOLD 4 and 1) against a reference model
module tb_mux16_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] a = '0;
    logic [15:0] gnt [2];
    logic [3:0] sel [2];
    logic busy [2];
    logic y [2];
    logic y_vld [2];
    int m_sel [2];
    int m_ptr [2];
    int m_beats [2];
    bit m_busy [2];
    bit m_y [2];
    bit m_vld [2];
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    mux16_rr_arbiter #(.MAX_HOLD(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a),
        .gnt(gnt[0]), .sel(sel[0]), .busy(busy[0]), .y(y[0]), .y_vld(y_vld[0])
    );
    mux16_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a),
        .gnt(gnt[1]), .sel(sel[1]), .busy(busy[1]), .y(y[1]), .y_vld(y_vld[1])
    );
    function automatic int lim(input int u);
        return (u == 0) ? 4 : 1;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // first requester at or after start (circularly), skipping excl
    function automatic int winner(input logic [15:0] r, input int start, input int excl);
        for (int off = 0; off < 16; off++) begin
            int j;
            j = (start + off) % 16;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction
    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_sel[u] = 0;
            m_ptr[u] = 0;
            m_beats[u] = 0;
            m_busy[u] = 0;
            m_y[u] = 0;
            m_vld[u] = 0;
        end
    endtask
    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            int w;
            if (!m_busy[u]) begin
                m_vld[u] = 0;
                w = winner(req, m_ptr[u], -1);
                if (w >= 0) begin
                    m_busy[u] = 1;
                    m_sel[u] = w;
                    m_beats[u] = 0;
                end
            end else if (!req[m_sel[u]]) begin
                m_vld[u] = 0;
                m_ptr[u] = (m_sel[u] + 1) % 16;
                w = winner(req, m_ptr[u], m_sel[u]);
                if (w < 0) m_busy[u] = 0;
                else begin
                    m_sel[u] = w;
                    m_beats[u] = 0;
                end
            end else begin
                m_y[u] = a[m_sel[u]];
                m_vld[u] = 1;
                m_beats[u]++;
                if (m_beats[u] == lim(u)) begin
                    m_beats[u] = 0;
                    w = winner(req, (m_sel[u] + 1) % 16, m_sel[u]);
                    if (w >= 0) begin
                        m_ptr[u] = (m_sel[u] + 1) % 16;
                        m_sel[u] = w;
                    end
                end
            end
        end
    endtask
    task automatic check_all();
        for (int u = 0; u < 2; u++) begin
            logic [15:0] eg;
            eg = m_busy[u] ? (16'h1 << m_sel[u]) : 16'h0;
            check($sformatf("gnt%0d", u), gnt[u], eg);
            check($sformatf("sel%0d", u), sel[u], m_sel[u]);
            check($sformatf("busy%0d", u), busy[u], m_busy[u]);
            check($sformatf("y%0d", u), y[u], m_y[u]);
            check($sformatf("y_vld%0d", u), y_vld[u], m_vld[u]);
            check($sformatf("onehot%0d", u), $onehot0(gnt[u]), 1);
            check($sformatf("gnt_sel%0d", u), busy[u] ? gnt[u][sel[u]] : (gnt[u] == 16'h0), 1);
        end
    endtask
    task automatic cycle(input logic [15:0] r, input logic [15:0] d);
        req = r;
        a = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("arst_gnt%0d", u), gnt[u], 0);
            check($sformatf("arst_sel%0d", u), sel[u], 0);
            check($sformatf("arst_busy%0d", u), busy[u], 0);
            check($sformatf("arst_y%0d", u), y[u], 0);
            check($sformatf("arst_vld%0d", u), y_vld[u], 0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        logic [15:0] r;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        cycle(16'h0001, 16'h0001);
        check("t1_gnt", gnt[0], 16'h0001);
        check("t1_sel", sel[0], 0);
        check("t1_busy", busy[0], 1);
        check("t1_vld0", y_vld[0], 0);
        cycle(16'h0001, 16'h0001);
        check("t1_y", y[0], 1);
        check("t1_vld", y_vld[0], 1);
        repeat (20) cycle(16'h8001, 16'($urandom));
        repeat (3) cycle(16'h0000, 16'($urandom));
        repeat (3) cycle(16'h8000, 16'($urandom));
        check("t3_pre_sel", sel[0], 15);
        cycle(16'h4004, 16'hFFFF);
        check("t3_gnt", gnt[0], 16'h0004);
        check("t3_vld", y_vld[0], 0);
        cycle(16'h0020, 16'($urandom));
        check("t4_grant", sel[0], 5);
        for (int i = 0; i < 10; i++) begin
            cycle(16'h0020, 16'($urandom));
            check("t4_sel", sel[0], 5);
            check("t4_vld", y_vld[0], 1);
        end
        async_reset();
        cycle(16'hFFFF, 16'($urandom));
        check("t5_gnt0", gnt[0], 16'h0001);
        check("t5_gnt1", gnt[1], 16'h0001);
        repeat (40) cycle(16'hFFFF, 16'($urandom));
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) r = 16'($urandom & $urandom & $urandom);
            cycle(r, 16'($urandom));
            if ($urandom_range(0, 59) == 0) async_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
